lmsm_sequencer: RTL and testbench

Multi-register transfer engine for the LM (load multiple) and SM (store multiple) instructions of the multicycle RISC core. When the controller dispatches an LM/SM opcode it pulses `start` with the 8-bit register mask (IR[7:0]) and the base address (contents of RA). The block then walks the mask from R0 to R7, one memory transfer per set bit, on consecutive addresses, and pulses `done`. It sits between the controller FSM, the register file and the memory port, and replaces the controller's own LM/SM counter loop.

---
 rtl/lmsm_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_lmsm_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmsm_sequencer.sv
// ---------------------------------------------------------------------------
// lmsm_sequencer
//
// Multi-register transfer engine for the LM (load multiple) and SM (store
// multiple) instructions. A start pulse captures an 8-bit register mask, a
// base address and the transfer direction. The engine then walks the mask
// from R0 up to R7. It makes one memory transfer per set bit, on consecutive
// addresses, and finishes with a one-cycle done pulse.
//
// Per-register sequence:
//   LM : SCAN -> REQ (mem_re until ack) -> WB (rf_we pulse)
//   SM : SCAN -> RD (register read)     -> REQ (mem_we until ack)
// With zero-wait memory each register costs three cycles.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             launch request, sampled only in IDLE
//   is_store          1 = SM, 0 = LM (captured with start)
//   mask              register mask, bit i selects Ri (captured with start)
//   base_addr         first memory address (captured with start)
//   busy              high in every state except IDLE
//   done              one-cycle completion pulse
//   mem_addr          current transfer address
//   mem_re / mem_we   read / write request, held until mem_ack
//   mem_wdata         store data, stable while mem_we is high
//   mem_rdata         load data, valid with mem_ack
//   mem_ack           transfer accepted / complete
//   rf_raddr          register read address (SM)
//   rf_rdata          register read data, combinational from rf_raddr
//   rf_we             register write pulse (LM)
//   rf_waddr          register write address
//   rf_wdata          register write data
//   count             transfers completed in the current operation (0..8)
// ---------------------------------------------------------------------------
module lmsm_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [7:0]        mask,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    RD   = 3'd2,
    REQ  = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] remaining;   // mask bits not yet transferred
  logic       mode;        // 1 = store (SM), 0 = load (LM)
  logic [2:0] cur_reg;     // register serviced by the current transfer

  // Index of the lowest set bit. The descending loop lets the lowest bit
  // win. The result is only used when at least one bit is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Both register-file addresses follow the register being serviced.
  assign rf_raddr = cur_reg;
  assign rf_waddr = cur_reg;

  // Control and all outputs are registered. The request strobes, rf_we and
  // done are set on the transition into the state that owns them, so they
  // line up exactly with REQ, WB and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= 8'd0;
      mode      <= 1'b0;
      cur_reg   <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rf_we     <= 1'b0;
      rf_wdata  <= '0;
      count     <= 4'd0;
    end else begin
      // Single-cycle pulses default low.
      done  <= 1'b0;
      rf_we <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            remaining <= mask;
            mem_addr  <= base_addr;
            mode      <= is_store;
            count     <= 4'd0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end

        SCAN: begin
          if (remaining == 8'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cur_reg   <= lowest_set(remaining);
            // Clearing the lowest set bit this way matches the encoder choice.
            remaining <= remaining & (remaining - 8'd1);
            if (mode) begin
              state <= RD;
            end else begin
              mem_re <= 1'b1;
              state  <= REQ;
            end
          end
        end

        RD: begin
          // rf_raddr already shows cur_reg, so rf_rdata is valid this cycle.
          mem_wdata <= rf_rdata;
          mem_we    <= 1'b1;
          state     <= REQ;
        end

        REQ: begin
          if (mem_ack) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (mode) begin
              mem_addr <= mem_addr + 1'b1;
              count    <= count + 4'd1;
              state    <= SCAN;
            end else begin
              rf_wdata <= mem_rdata;
              rf_we    <= 1'b1;
              state    <= WB;
            end
          end
        end

        WB: begin
          mem_addr <= mem_addr + 1'b1;
          count    <= count + 4'd1;
          state    <= SCAN;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy   <= 1'b0;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lmsm_sequencer
//
// Directed bench for lmsm_sequencer. The bench provides three models:
//   - a register file with a combinational read port and a clocked write
//     port, plus a side port that preloads values into it;
//   - a memory that returns fixed data per address and acks after a
//     configurable number of wait cycles;
//   - monitors that log accepted transfers, register writes, request-high
//     cycles and done pulses.
// Each test task drives one scenario and checks results against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_lmsm_sequencer;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              is_store = 1'b0;
  logic [7:0]        mask = 8'd0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy, done, mem_re, mem_we, mem_ack, rf_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, rf_rdata, rf_wdata;
  logic [2:0]        rf_raddr, rf_waddr;
  logic [3:0]        count;

  lmsm_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .mask(mask), .base_addr(base_addr), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Register-file model and its preload port.
  logic [DATA_W-1:0] regs [8];
  logic              pre_en = 1'b0;
  logic [2:0]        pre_addr = 3'd0;
  logic [DATA_W-1:0] pre_data = '0;
  assign rf_rdata = regs[rf_raddr];

  // Memory model: fixed data per address, ack after wait_cfg wait cycles.
  int wait_cfg = 0;
  int wcnt = 0;
  function automatic logic [DATA_W-1:0] rdata_f(input logic [ADDR_W-1:0] a);
    if (a == 16'h0100) return 16'hAAAA;
    if (a == 16'h0101) return 16'h5555;
    return a ^ 16'hC3C3;
  endfunction
  assign mem_ack   = (mem_re | mem_we) && (wcnt >= wait_cfg);
  assign mem_rdata = rdata_f(mem_addr);

  // Monitor logs. These only ever grow; tasks take snapshots and look at
  // the difference.
  logic [ADDR_W-1:0] acc_addr [$];
  logic [DATA_W-1:0] acc_wdata [$];
  logic [2:0]        wr_addr_q [$];
  int re_cycles = 0, we_cycles = 0, rfwe_pulses = 0, done_pulses = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((mem_re | mem_we) && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_re) re_cycles <= re_cycles + 1;
    if (mem_we) we_cycles <= we_cycles + 1;
    if (done) done_pulses <= done_pulses + 1;
    if (mem_ack) begin
      acc_addr.push_back(mem_addr);
      acc_wdata.push_back(mem_wdata);
    end
    if (pre_en) regs[pre_addr] <= pre_data;
    else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
      wr_addr_q.push_back(rf_waddr);
      rfwe_pulses <= rfwe_pulses + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [DATA_W-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  // Presents start for one edge. e is the edge count of the sampling edge.
  task automatic launch(input logic st, input logic [7:0] m,
                        input logic [ADDR_W-1:0] b, output int e);
    start = 1'b1; is_store = st; mask = m; base_addr = b;
    tick();
    e = cyc;
    start = 1'b0; is_store = 1'b0; mask = 8'd0; base_addr = '0;
  endtask

  // Latency counts the cycle right after the sampling edge as cycle 1.
  // Returns -1 if done never shows up within the budget.
  task automatic wait_done(input int e, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        lat = cyc - e + 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests++;
    if ({busy, done, mem_re, mem_we, rf_we} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, mem_re, mem_we, rf_we});
    end
    tests++;
    if ({mem_addr, mem_wdata, rf_wdata, count, rf_raddr, rf_waddr} !== '0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h rfw=%h count=%0d expected all 0",
               mem_addr, mem_wdata, rf_wdata, count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lm_basic();
    int e, lat, a0, w0;
    wait_cfg = 0;
    a0 = acc_addr.size(); w0 = wr_addr_q.size();
    launch(1'b0, 8'h05, 16'h0100, e);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL lm_busy: got %b expected 1", busy); end
    wait_done(e, 50, lat);
    tests++;
    if (lat !== 8) begin fails++; $display("FAIL lm_latency: got %0d expected 8", lat); end
    tests++;
    if (count !== 4'd2) begin fails++; $display("FAIL lm_count: got %0d expected 2", count); end
    tests++;
    if (acc_addr.size() - a0 !== 2) begin
      fails++; $display("FAIL lm_nxfer: got %0d expected 2", acc_addr.size() - a0);
    end else begin
      tests++;
      if (acc_addr[a0] !== 16'h0100 || acc_addr[a0+1] !== 16'h0101) begin
        fails++;
        $display("FAIL lm_addrs: got %h,%h expected 0100,0101", acc_addr[a0], acc_addr[a0+1]);
      end
    end
    tests++;
    if (regs[0] !== 16'hAAAA) begin fails++; $display("FAIL lm_r0: got %h expected aaaa", regs[0]); end
    tests++;
    if (regs[2] !== 16'h5555) begin fails++; $display("FAIL lm_r2: got %h expected 5555", regs[2]); end
    tests++;
    if (wr_addr_q.size() - w0 !== 2 || wr_addr_q[w0] !== 3'd0 || wr_addr_q[w0+1] !== 3'd2) begin
      fails++; $display("FAIL lm_wr_order: got %0d writes expected R0,R2", wr_addr_q.size() - w0);
    end
    tick();
    tests++;
    if ({busy, done} !== 2'b00) begin fails++; $display("FAIL lm_after_done: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_sm_wait();
    int e, lat, a0, we0, rf0;
    preload(3'd7, 16'h1234);
    wait_cfg = 3;
    a0 = acc_addr.size(); we0 = we_cycles; rf0 = rfwe_pulses;
    launch(1'b1, 8'h80, 16'h0200, e);
    wait_done(e, 50, lat);
    tests++;
    if (lat !== 8) begin fails++; $display("FAIL sm_latency: got %0d expected 8", lat); end
    tests++;
    if (we_cycles - we0 !== 4) begin fails++; $display("FAIL sm_we_cycles: got %0d expected 4", we_cycles - we0); end
    tests++;
    if (acc_addr.size() - a0 !== 1 || acc_addr[a0] !== 16'h0200 || acc_wdata[a0] !== 16'h1234) begin
      fails++; $display("FAIL sm_xfer: got %0d transfers expected one at 0200 data 1234", acc_addr.size() - a0);
    end
    tests++;
    if (rfwe_pulses - rf0 !== 0) begin fails++; $display("FAIL sm_rf_we: got %0d expected 0", rfwe_pulses - rf0); end
    tests++;
    if (count !== 4'd1 || mem_addr !== 16'h0201) begin
      fails++; $display("FAIL sm_count_addr: got %0d/%h expected 1/0201", count, mem_addr);
    end
    tick();
  endtask

  task automatic test_empty_mask();
    int e, lat, re0, we0, rf0;
    wait_cfg = 0;
    re0 = re_cycles; we0 = we_cycles; rf0 = rfwe_pulses;
    launch(1'b0, 8'h00, 16'h0300, e);
    wait_done(e, 20, lat);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL empty_latency: got %0d expected 2", lat); end
    tests++;
    if (re_cycles - re0 + we_cycles - we0 + rfwe_pulses - rf0 !== 0) begin
      fails++; $display("FAIL empty_traffic: got %0d strobes expected 0", re_cycles - re0 + we_cycles - we0 + rfwe_pulses - rf0);
    end
    tests++;
    if (count !== 4'd0) begin fails++; $display("FAIL empty_count: got %0d expected 0", count); end
    tick();
  endtask

  task automatic test_lm_wrap();
    int e, lat, a0, w0;
    logic [ADDR_W-1:0] exp_addr [8];
    exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    wait_cfg = 0;
    a0 = acc_addr.size(); w0 = wr_addr_q.size();
    launch(1'b0, 8'hFF, 16'hFFFE, e);
    wait_done(e, 100, lat);
    tests++;
    if (lat !== 26) begin fails++; $display("FAIL wrap_latency: got %0d expected 26", lat); end
    tests++;
    if (count !== 4'd8) begin fails++; $display("FAIL wrap_count: got %0d expected 8", count); end
    tests++;
    if (acc_addr.size() - a0 !== 8 || wr_addr_q.size() - w0 !== 8) begin
      fails++; $display("FAIL wrap_nxfer: got %0d/%0d expected 8/8", acc_addr.size() - a0, wr_addr_q.size() - w0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (acc_addr[a0+i] !== exp_addr[i] || wr_addr_q[w0+i] !== 3'(i) ||
            regs[i] !== (exp_addr[i] ^ 16'hC3C3)) begin
          fails++;
          $display("FAIL wrap_xfer%0d: addr=%h reg=R%0d data=%h expected addr=%h R%0d data=%h",
                   i, acc_addr[a0+i], wr_addr_q[w0+i], regs[i], exp_addr[i], i, exp_addr[i] ^ 16'hC3C3);
        end
      end
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int e, e2, lat, a0;
    wait_cfg = 1;
    a0 = acc_addr.size();
    launch(1'b0, 8'h06, 16'h0400, e);
    // Keep start high with different parameters while the operation runs.
    start = 1'b1; is_store = 1'b1; mask = 8'hFF; base_addr = 16'h0700;
    wait_done(e, 60, lat);
    tests++;
    if (lat !== 10) begin fails++; $display("FAIL busy_latency: got %0d expected 10", lat); end
    tests++;
    if (count !== 4'd2 || acc_addr.size() - a0 !== 2) begin
      fails++; $display("FAIL busy_ignored: got count %0d xfers %0d expected 2/2", count, acc_addr.size() - a0);
    end
    // Still in DONE: start stays high, now with the next operation's fields.
    mask = 8'h01; base_addr = 16'h0500; is_store = 1'b1;
    tick();
    tests++;
    if ({busy, done} !== 2'b00) begin fails++; $display("FAIL done_start_ignored: got %b expected 00", {busy, done}); end
    tick();
    e2 = cyc;
    start = 1'b0; is_store = 1'b0; mask = 8'd0; base_addr = '0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL restart_busy: got %b expected 1", busy); end
    a0 = acc_addr.size();
    wait_done(e2, 40, lat);
    tests++;
    if (lat !== 6) begin fails++; $display("FAIL restart_latency: got %0d expected 6", lat); end
    tests++;
    if (acc_addr.size() - a0 !== 1 || acc_addr[a0] !== 16'h0500 || acc_wdata[a0] !== 16'h3C3D) begin
      fails++; $display("FAIL restart_xfer: got %0d transfers, wdata %h expected one at 0500 data 3c3d",
                        acc_addr.size() - a0, mem_wdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int e, d0;
    wait_cfg = 1000;
    launch(1'b0, 8'h01, 16'h0600, e);
    tick();
    tests++;
    if (mem_re !== 1'b1) begin fails++; $display("FAIL mid_req: got mem_re %b expected 1", mem_re); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, mem_re, mem_we, rf_we} !== 5'b0 || mem_addr !== '0 || count !== 4'd0) begin
      fails++; $display("FAIL mid_reset_outputs: ctrl=%b addr=%h count=%0d expected 0",
                        {busy, done, mem_re, mem_we, rf_we}, mem_addr, count);
    end
    d0 = done_pulses;
    tick(); tick(); tick();
    tests++;
    if (done_pulses !== d0 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_reset_no_done: got %0d pulses busy %b expected 0/0", done_pulses - d0, busy);
    end
    rst_n = 1'b1;
    wait_cfg = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lm_basic();
    test_sm_wait();
    test_empty_mask();
    test_lm_wrap();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
